ram_dist_rd_stream: RTL and testbench

- Read-side streaming engine for the registered-read-address dual-port distributed RAM (`ram_dist_dp`).
- Accepts a command giving a start address and a word count.
- Drives the RAM read port one address per cycle and absorbs the RAM's one-cycle read latency in a 2-entry output buffer.
- Presents the words as a valid/ready stream with a last flag. Used to drain buffers that the write side filled.

---
 rtl/ram_dist_rd_stream.sv | 137 +++++++++++++
 tb/tb_ram_dist_rd_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dist_rd_stream.sv
// Read-side streaming engine for a registered-read-address distributed RAM.
// Optional abort input is compiled in when RD_STREAM_ABORT_EN is defined.
module ram_dist_rd_stream #(
  parameter int DATAWIDTH = 4,
  parameter int ADDRWIDTH = 4,
  parameter int LENWIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [LENWIDTH-1:0]  cmd_len,
  output logic [ADDRWIDTH-1:0] rd_addr,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_last,
`ifdef RD_STREAM_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               state_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [LENWIDTH-1:0]  remaining_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic [DATAWIDTH-1:0] buf_data_q [2];
  logic                 buf_last_q [2];
  logic                 rd_ptr_q;
  logic                 wr_ptr_q;
  logic [1:0]           occ_q;
  logic                 done_q;

  logic       pop;
  logic       issue;
  logic       abort_hit;
  logic [1:0] occ_d;

`ifdef RD_STREAM_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign rd_addr   = addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_last  = out_valid && buf_last_q[rd_ptr_q];
  assign done      = done_q;
  assign pop       = out_valid && out_ready;

  // Occupancy after this edge must leave room for the word we are about to issue.
  always_comb begin
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    issue = (state_q == S_RUN) && (remaining_q != '0) && (occ_d < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      done_q          <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else if (abort_hit) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      done_q          <= 1'b1;
    end else begin
      done_q <= 1'b0;

      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= rd_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q           <= occ_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LENWIDTH'(1));

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len != '0) begin
              addr_q      <= cmd_addr;
              remaining_q <= cmd_len;
              state_q     <= S_RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            addr_q      <= addr_q + ADDRWIDTH'(1);
            remaining_q <= remaining_q - LENWIDTH'(1);
            if (remaining_q == LENWIDTH'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Popping the last-flagged word empties the buffer with nothing in flight.
          if (pop && out_last) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dist_rd_stream.sv
// Self-checking bench for ram_dist_rd_stream with a small registered-read RAM model.
// Expected streams are built from the RAM contents and the command (addr, len).
module tb_ram_dist_rd_stream;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_addr = 4'h0;
  logic [4:0] cmd_len = 5'd0;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_last;
  logic       done;
`ifdef RD_STREAM_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [3:0] mem [16];
  logic [3:0] ram_addr_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_addr_q <= rd_addr;
  assign rd_data = mem[ram_addr_q];

  ram_dist_rd_stream #(.DATAWIDTH(4), .ADDRWIDTH(4), .LENWIDTH(5)) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef RD_STREAM_ABORT_EN
    .abort     (abort),
`endif
    .done      (done)
  );

  task automatic test_reset();
    reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_l = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (rd_addr !== 4'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    $display("reset: cmd_ready=%b out_valid=%b done=%b rd_addr=%h", cmd_ready, out_valid, done, rd_addr);
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready low for cycles 3..7; mode 2: random out_ready.
  task automatic test_command(input logic [3:0] a, input logic [4:0] n, input int mode, input string tag);
    logic [4:0] exp_q[$];
    logic [4:0] exp_w;
    logic       ov, ol, dn, rdy, cr;
    logic [3:0] od, ra, issued;
    logic       prev_ov, prev_rdy, prev_ol;
    logic [3:0] prev_od;
    logic       exp_dn;
    int         pops, last_pop_t, t, waited;
    bit         finished;

    pops = 0; last_pop_t = -1; finished = 0;
    prev_ov = 1'b0; prev_rdy = 1'b1; prev_ol = 1'b0; prev_od = 4'h0;
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back({(i == int'(n) - 1), mem[4'(int'(a) + i)]});

    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s cmd_ready_wait: got %b want 1", tag, cmd_ready); end

    cmd_valid = 1'b1; cmd_addr = a; cmd_len = n; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    t = 1;
    while (!finished && t <= 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(t >= 3 && t < 8);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;
      ov = out_valid; od = out_data; ol = out_last; dn = done; ra = rd_addr; cr = cmd_ready;

      exp_dn = (n == 5'd0) ? (t == 1) : (last_pop_t > 0 && t == last_pop_t + 1);
      n_checks++;
      if (dn !== exp_dn) begin n_fail++; $display("FAIL %s done t=%0d: got %b want %b", tag, t, dn, exp_dn); end

      if (t == 1) begin
        n_checks++;
        if (cr !== (n == 5'd0)) begin n_fail++; $display("FAIL %s cmd_ready_t1: got %b want %b", tag, cr, (n == 5'd0)); end
      end
      if (n == 5'd0 || t < 3) begin
        n_checks++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL %s early_valid t=%0d: got %b want 0", tag, t, ov); end
      end else if (t == 3 || (mode == 0 && t < int'(n) + 3)) begin
        n_checks++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL %s valid t=%0d: got %b want 1", tag, t, ov); end
      end
      if (mode == 0 && n != 5'd0 && t <= int'(n)) begin
        n_checks++;
        if (ra !== 4'(int'(a) + t - 1)) begin n_fail++; $display("FAIL %s rd_addr t=%0d: got %h want %h", tag, t, ra, 4'(int'(a) + t - 1)); end
      end
      if (n != 5'd0 && n < 5'd16) begin
        issued = ra - a;
        n_checks++;
        if (int'(issued) - pops > 2) begin n_fail++; $display("FAIL %s outstanding t=%0d: got %0d want <=2", tag, t, int'(issued) - pops); end
        if (mode == 1 && t == 7 && n >= 5'd3) begin
          n_checks++;
          if (int'(issued) - pops != 2) begin n_fail++; $display("FAIL %s stall_fill: got %0d want 2", tag, int'(issued) - pops); end
        end
      end
      if (prev_ov && !prev_rdy) begin
        n_checks++;
        if (ov !== 1'b1 || od !== prev_od || ol !== prev_ol) begin
          n_fail++;
          $display("FAIL %s hold t=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", tag, t, ov, od, ol, prev_od, prev_ol);
        end
      end
      if (ov && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_word t=%0d: got d=%h l=%b want none", tag, t, od, ol);
        end else begin
          exp_w = exp_q.pop_front();
          if ({ol, od} !== exp_w) begin n_fail++; $display("FAIL %s word%0d: got l=%b d=%h want l=%b d=%h", tag, pops, ol, od, exp_w[4], exp_w[3:0]); end
          pops++;
          if (pops == int'(n)) last_pop_t = t;
        end
      end

      if (dn === 1'b1) begin
        finished = 1;
        n_checks++;
        if (exp_q.size() != 0 || cr !== 1'b1) begin n_fail++; $display("FAIL %s completion: got left=%0d ready=%b want left=0 ready=1", tag, exp_q.size(), cr); end
      end else begin
        prev_ov = ov; prev_rdy = rdy; prev_od = od; prev_ol = ol;
        @(posedge clk); #1;
        t++;
      end
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no done want done within 300 cycles", tag);
    end
    $display("%s: addr=%h len=%0d mode=%0d words=%0d cycles=%0d", tag, a, n, mode, pops, t);
  endtask

  task automatic test_basic();
    test_command(4'h2, 5'd4, 0, "basic");
  endtask

  task automatic test_wrap();
    test_command(4'hE, 5'd3, 0, "wrap");
  endtask

  task automatic test_back_to_back();
    test_command(4'hA, 5'd31, 0, "long31");
  endtask

  task automatic test_backpressure();
    test_command(4'h2, 5'd4, 1, "backpressure");
  endtask

  task automatic test_zero_len();
    test_command(4'h5, 5'd0, 0, "zero_len");
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_len_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_addr = 4'h7; cmd_len = 5'd8; out_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if (out_valid !== 1'b1 || rd_addr !== 4'h9) begin n_fail++; $display("FAIL reset_mid_fill: got v=%b a=%h want v=1 a=9", out_valid, rd_addr); end
    reset_l = 1'b0;
    @(posedge clk); #1;
    reset_l = 1'b1;
    out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid: got %b want 0", out_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b want 1", cmd_ready); end
    n_checks++; if (rd_addr !== 4'h0) begin n_fail++; $display("FAIL reset_mid_addr: got %h want 0", rd_addr); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_quiet%0d: got d=%b v=%b want 0 0", i, done, out_valid); end
      @(posedge clk); #1;
    end
    $display("reset_mid: flushed, cmd_ready=%b", cmd_ready);
    test_command(4'h1, 5'd5, 0, "after_reset");
  endtask

`ifdef RD_STREAM_ABORT_EN
  task automatic test_abort();
    int pops, t;
    pops = 0; t = 0;
    cmd_valid = 1'b1; cmd_addr = 4'h3; cmd_len = 5'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (pops < 3 && t < 50) begin
      if (out_valid) begin
        n_checks++;
        if (out_data !== mem[4'(3 + pops)]) begin n_fail++; $display("FAIL abort_word%0d: got %h want %h", pops, out_data, mem[4'(3 + pops)]); end
        pops++;
      end
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (pops != 3) begin n_fail++; $display("FAIL abort_pops: got %0d want 3", pops); end
    out_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b want 1", done); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_after: got d=%b v=%b want 0 0", done, out_valid); end
    out_ready = 1'b1;
    $display("abort: aborted after %0d words", pops);
    test_command(4'hC, 5'd2, 0, "after_abort");
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      test_command(4'($urandom), 5'($urandom_range(0, 12)), (k % 4 == 3) ? 1 : 2, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
`ifdef RD_STREAM_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
